branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Sequences the datapath comparator for conditional branches: captures OP1/R15 and the branch descriptor from decode, presents the operands to the comparator, and decodes the 2-bit comparator result against the branch condition.
- On a taken branch, issues a one-cycle PC load with the computed target and holds a pipeline flush for a fixed number of cycles.
- Sits between the decode stage, the comparator and the fetch/PC logic.
- Stalls decode while busy and waits out a pending R15 write hazard.

Parameters:
DATA_W, 16, width of operands, PC and target
OFFSET_W, 8, width of the signed branch offset, in words
FLUSH_CYCLES, 2, cycles flush is held after a taken branch; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
br_valid  input  1  decode presents a branch instruction
br_ready  output  1  block can accept a branch (state IDLE)
br_cond  input  2  00 BEQ, 01 BLT (OP1<R15), 10 BGT (OP1>R15), 11 JMP (unconditional)
br_offset  input  OFFSET_W  signed word offset
br_pc  input  DATA_W  PC of the branch instruction
op1_in  input  DATA_W  OP1 register value
r15_in  input  DATA_W  R15 register value
r15_pending  input  1  an older in-flight instruction will still write R15
cmp_op1  output  DATA_W  registered OP1 driven to the comparator
cmp_r15  output  DATA_W  registered R15 driven to the comparator
cmp_branch  input  2  comparator result: 00 equal, 01 OP1<R15, 10 OP1>R15, 11 invalid
pc_load  output  1  one-cycle strobe: fetch loads pc_target
pc_target  output  DATA_W  branch target
flush  output  1  squash younger instructions in fetch/decode
taken  output  1  result of the last resolved branch; holds until the next resolve
taken_cnt  output  16  count of taken branches; wraps at 0xFFFF -> 0x0000

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - pc_load, flush, taken, cmp_op1, cmp_r15, pc_target and taken_cnt go to 0.
  - br_ready goes to 1.
  - Reset mid-operation discards the branch in flight; no pc_load is issued.
- br_ready = (state==IDLE). It is decoded from the state register; there is no combinational path from br_valid.
- Accept occurs when br_valid & br_ready at a rising edge (cycle 0).
  - Captured: op1_in -> cmp_op1, r15_in -> cmp_r15, br_cond, br_offset, br_pc.
  - Next state is WAIT_R15 if r15_pending=1, else COMPARE.
- WAIT_R15:
  - Each cycle re-captures r15_in into cmp_r15.
  - When r15_pending=0, captures r15_in that cycle and goes to COMPARE.
  - There is no timeout.
- COMPARE (one cycle): cmp_branch is sampled at the end of the cycle.
  - taken_d = JMP, or (BEQ & 00), or (BLT & 01), or (BGT & 10).
  - A cmp_branch of 11 is never taken for a conditional branch.
  - taken <= taken_d.
  - If taken_d: pc_target <= br_pc + 1 + sext(br_offset), modulo 2^DATA_W; taken_cnt increments; next state is FLUSH.
  - Else: next state is IDLE.
- FLUSH:
  - pc_load=1 in the first FLUSH cycle only.
  - flush=1 for exactly FLUSH_CYCLES cycles.
  - Then IDLE.
- Latency, not taken: accept at cycle 0, COMPARE at cycle 1, br_ready=1 at cycle 2.
- Latency, taken: pc_load at cycle 2; flush at cycles 2..1+FLUSH_CYCLES; br_ready=1 at cycle 2+FLUSH_CYCLES.
- Each r15_pending cycle adds one cycle to both latencies.
- br_valid while not IDLE is ignored. Decode must hold the instruction until accepted.
- pc_target holds its value outside taken resolves.
- cmp_op1/cmp_r15 hold their values until the next accept.

Decomposition:
- Shared definitions include (branch_defs.v):
  - br_cond codes
  - cmp_branch codes (shared with the comparator and its fixture)
  - state encodings IDLE/WAIT_R15/COMPARE/FLUSH
- One combinational sub-module, branch_cond_decode (br_cond, cmp_branch -> taken_d), so the decode truth table can be tested exhaustively on its own.
- The comparator itself stays in the datapath and is not instantiated here.

Test Plan:
- Reset: hold rst_n=0 mid-FLUSH -> flush and pc_load drop immediately; br_ready=1; taken_cnt=0.
- BEQ taken: OP1=0x0007, R15=0x0007, br_pc=0x0010, offset=+4, cmp_branch=00 -> pc_load=1 at cycle 2, pc_target=0x0015, flush high for cycles 2-3, br_ready=1 at cycle 4, taken_cnt=1.
- BLT not taken: OP1=0x0007, R15=0x0005, cmp_branch=10 -> no pc_load, no flush, taken=0, br_ready=1 at cycle 2.
- R15 hazard: r15_pending=1 for 3 cycles, r15_in changes 0x0001 -> 0x0005; BGT with OP1=0x0007 -> cmp_r15=0x0005 at COMPARE, taken, pc_load at cycle 5.
- Wrap and JMP: br_pc=0xFFFE, offset=+1, JMP with cmp_branch=11 -> pc_target=0x0000 taken; separately offset=-128 (0x80) at br_pc=0x0005 -> pc_target=0xFF86.
- Back-to-back: br_valid held continuously for two branches -> second accepted exactly on the cycle br_ready returns; the first branch's captured operands are not corrupted.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared codes for the branch controller: branch conditions, comparator results
// and controller states.
package branch_ctrl_pkg;

   typedef enum logic [1:0] {
      COND_BEQ = 2'b00,
      COND_BLT = 2'b01,
      COND_BGT = 2'b10,
      COND_JMP = 2'b11
   } br_cond_e;

   // Shared with the datapath comparator and its fixture.
   typedef enum logic [1:0] {
      CMP_EQ  = 2'b00,
      CMP_LT  = 2'b01,
      CMP_GT  = 2'b10,
      CMP_INV = 2'b11
   } cmp_res_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_WAIT_R15 = 2'b01,
      ST_COMPARE  = 2'b10,
      ST_FLUSH    = 2'b11
   } br_state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode/comparator/fetch-facing signals of the branch controller.
// The controller uses the slave modport; its surroundings drive the master side.
interface branch_ctrl_if #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned OFFSET_W = 8
);
   logic                br_valid;
   logic                br_ready;
   logic [1:0]          br_cond;
   logic [OFFSET_W-1:0] br_offset;
   logic [DATA_W-1:0]   br_pc;
   logic [DATA_W-1:0]   op1_in;
   logic [DATA_W-1:0]   r15_in;
   logic                r15_pending;
   logic [DATA_W-1:0]   cmp_op1;
   logic [DATA_W-1:0]   cmp_r15;
   logic [1:0]          cmp_branch;
   logic                pc_load;
   logic [DATA_W-1:0]   pc_target;
   logic                flush;
   logic                taken;
   logic [15:0]         taken_cnt;

   modport master (
      output br_valid, br_cond, br_offset, br_pc, op1_in, r15_in, r15_pending, cmp_branch,
      input  br_ready, cmp_op1, cmp_r15, pc_load, pc_target, flush, taken, taken_cnt
   );

   modport slave (
      input  br_valid, br_cond, br_offset, br_pc, op1_in, r15_in, r15_pending, cmp_branch,
      output br_ready, cmp_op1, cmp_r15, pc_load, pc_target, flush, taken, taken_cnt
   );
endinterface

// File: rtl/branch_cond_decode.sv
// Combinational branch decision: branch condition vs. 2-bit comparator result.
module branch_cond_decode
   import branch_ctrl_pkg::*;
(
   input  logic [1:0] cond_i,
   input  logic [1:0] cmp_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         COND_BEQ: taken_o = (cmp_i == CMP_EQ);
         COND_BLT: taken_o = (cmp_i == CMP_LT);
         COND_BGT: taken_o = (cmp_i == CMP_GT);
         COND_JMP: taken_o = 1'b1;
         default:  taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer: captures operands, waits out R15 hazards,
// resolves via the comparator result and issues PC load plus a timed flush.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned OFFSET_W     = 8,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   branch_ctrl_if.slave  bus
);

   br_state_e           state_q;
   logic [DATA_W-1:0]   op1_q;
   logic [DATA_W-1:0]   r15_q;
   logic [1:0]          cond_q;
   logic [OFFSET_W-1:0] offset_q;
   logic [DATA_W-1:0]   pc_q;
   logic                pc_load_q;
   logic                flush_q;
   logic                taken_q;
   logic [DATA_W-1:0]   target_q;
   logic [15:0]         cnt_q;
   logic [3:0]          flush_cnt_q;

   logic                taken_d;
   logic [DATA_W-1:0]   target_d;

   branch_cond_decode u_cond_decode (
      .cond_i  (cond_q),
      .cmp_i   (bus.cmp_branch),
      .taken_o (taken_d)
   );

   assign target_d = pc_q + DATA_W'(1)
                   + {{(DATA_W-OFFSET_W){offset_q[OFFSET_W-1]}}, offset_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op1_q       <= '0;
         r15_q       <= '0;
         cond_q      <= '0;
         offset_q    <= '0;
         pc_q        <= '0;
         pc_load_q   <= 1'b0;
         flush_q     <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         cnt_q       <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_load_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.br_valid) begin
                  op1_q    <= bus.op1_in;
                  r15_q    <= bus.r15_in;
                  cond_q   <= bus.br_cond;
                  offset_q <= bus.br_offset;
                  pc_q     <= bus.br_pc;
                  state_q  <= bus.r15_pending ? ST_WAIT_R15 : ST_COMPARE;
               end
            end
            ST_WAIT_R15: begin
               r15_q <= bus.r15_in;
               if (!bus.r15_pending) state_q <= ST_COMPARE;
            end
            ST_COMPARE: begin
               taken_q <= taken_d;
               if (taken_d) begin
                  target_q    <= target_d;
                  cnt_q       <= cnt_q + 16'd1;
                  pc_load_q   <= 1'b1;
                  flush_q     <= 1'b1;
                  flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
                  state_q     <= ST_FLUSH;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               // flush_q was raised on entry; counter holds the remaining cycles.
               if (flush_cnt_q == '0) begin
                  flush_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 4'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.br_ready  = (state_q == ST_IDLE);
   assign bus.cmp_op1   = op1_q;
   assign bus.cmp_r15   = r15_q;
   assign bus.pc_load   = pc_load_q;
   assign bus.pc_target = target_q;
   assign bus.flush     = flush_q;
   assign bus.taken     = taken_q;
   assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl and its condition decoder.
module tb_branch_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   branch_ctrl_if #(.DATA_W(16), .OFFSET_W(8)) bus ();

   branch_ctrl #(.DATA_W(16), .OFFSET_W(8), .FLUSH_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [1:0] t_cond;
   logic [1:0] t_cmp;
   logic       t_taken;

   branch_cond_decode u_dec (
      .cond_i  (t_cond),
      .cmp_i   (t_cmp),
      .taken_o (t_taken)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [1:0] cond, input logic [7:0] off, input logic [15:0] pc,
                          input logic [15:0] op1, input logic [15:0] r15, input logic pend,
                          input logic [1:0] cmp);
      bus.br_valid    = 1'b1;
      bus.br_cond     = cond;
      bus.br_offset   = off;
      bus.br_pc       = pc;
      bus.op1_in      = op1;
      bus.r15_in      = r15;
      bus.r15_pending = pend;
      bus.cmp_branch  = cmp;
   endtask

   initial begin
      logic [15:0] exp_tbl;
      exp_tbl = 16'hF421;  // index {cond,cmp}

      bus.br_valid = 1'b0; bus.br_cond = '0; bus.br_offset = '0; bus.br_pc = '0;
      bus.op1_in = '0; bus.r15_in = '0; bus.r15_pending = 1'b0; bus.cmp_branch = '0;
      t_cond = '0; t_cmp = '0;

      // Decoder truth table
      for (int i = 0; i < 16; i++) begin
         t_cond = 2'(i >> 2);
         t_cmp  = 2'(i);
         #1;
         check($sformatf("decode_%0d", i), {31'd0, t_taken}, {31'd0, exp_tbl[i]});
      end

      // Reset values
      tick(); tick();
      check("rst_ready", bus.br_ready, 1);
      check("rst_pc_load", bus.pc_load, 0);
      check("rst_flush", bus.flush, 0);
      check("rst_taken", bus.taken, 0);
      check("rst_cmp_op1", bus.cmp_op1, 0);
      check("rst_target", bus.pc_target, 0);
      check("rst_cnt", bus.taken_cnt, 0);
      rst_n = 1'b1;
      tick();

      // BEQ taken: target 0x10+1+4 = 0x15
      present(2'b00, 8'd4, 16'h0010, 16'h0007, 16'h0007, 1'b0, 2'b00);
      check("beq_c0_ready", bus.br_ready, 1);
      tick(); bus.br_valid = 1'b0;
      check("beq_c1_ready", bus.br_ready, 0);
      check("beq_c1_op1", bus.cmp_op1, 16'h0007);
      check("beq_c1_r15", bus.cmp_r15, 16'h0007);
      check("beq_c1_pc_load", bus.pc_load, 0);
      tick();
      check("beq_c2_pc_load", bus.pc_load, 1);
      check("beq_c2_flush", bus.flush, 1);
      check("beq_c2_target", bus.pc_target, 16'h0015);
      check("beq_c2_taken", bus.taken, 1);
      check("beq_c2_cnt", bus.taken_cnt, 1);
      tick();
      check("beq_c3_pc_load", bus.pc_load, 0);
      check("beq_c3_flush", bus.flush, 1);
      check("beq_c3_ready", bus.br_ready, 0);
      tick();
      check("beq_c4_flush", bus.flush, 0);
      check("beq_c4_ready", bus.br_ready, 1);

      // BLT not taken
      present(2'b01, 8'd9, 16'h0040, 16'h0007, 16'h0005, 1'b0, 2'b10);
      tick(); bus.br_valid = 1'b0;
      check("blt_c1_ready", bus.br_ready, 0);
      tick();
      check("blt_c2_ready", bus.br_ready, 1);
      check("blt_c2_pc_load", bus.pc_load, 0);
      check("blt_c2_flush", bus.flush, 0);
      check("blt_c2_taken", bus.taken, 0);
      check("blt_c2_target_hold", bus.pc_target, 16'h0015);
      check("blt_c2_cnt", bus.taken_cnt, 1);

      // R15 hazard: pending during cycles 0..2, BGT target 0x20+1+2 = 0x23
      present(2'b10, 8'd2, 16'h0020, 16'h0007, 16'h0001, 1'b1, 2'b10);
      tick(); bus.br_valid = 1'b0; bus.r15_in = 16'h0003;
      check("haz_c1_r15", bus.cmp_r15, 16'h0001);
      check("haz_c1_ready", bus.br_ready, 0);
      tick(); bus.r15_in = 16'h0004;
      check("haz_c2_r15", bus.cmp_r15, 16'h0003);
      tick(); bus.r15_in = 16'h0005; bus.r15_pending = 1'b0;
      check("haz_c3_pc_load", bus.pc_load, 0);
      tick();
      check("haz_c4_r15", bus.cmp_r15, 16'h0005);
      check("haz_c4_pc_load", bus.pc_load, 0);
      tick();
      check("haz_c5_pc_load", bus.pc_load, 1);
      check("haz_c5_target", bus.pc_target, 16'h0023);
      check("haz_c5_cnt", bus.taken_cnt, 2);
      tick(); tick();
      check("haz_c7_ready", bus.br_ready, 1);

      // JMP with invalid compare result, target wraps to 0
      present(2'b11, 8'h01, 16'hFFFE, 16'h1111, 16'h2222, 1'b0, 2'b11);
      tick(); bus.br_valid = 1'b0;
      tick();
      check("jmp_wrap_pc_load", bus.pc_load, 1);
      check("jmp_wrap_target", bus.pc_target, 16'h0000);
      check("jmp_wrap_cnt", bus.taken_cnt, 3);
      tick(); tick();
      check("jmp_wrap_ready", bus.br_ready, 1);

      // BEQ with invalid compare result is not taken
      present(2'b00, 8'h01, 16'h0100, 16'h0001, 16'h0001, 1'b0, 2'b11);
      tick(); bus.br_valid = 1'b0;
      tick();
      check("beq_inv_taken", bus.taken, 0);
      check("beq_inv_pc_load", bus.pc_load, 0);
      check("beq_inv_cnt", bus.taken_cnt, 3);

      // Negative offset: 5+1-128 = 0xFF86
      present(2'b11, 8'h80, 16'h0005, 16'h0000, 16'h0000, 1'b0, 2'b00);
      tick(); bus.br_valid = 1'b0;
      tick();
      check("neg_off_target", bus.pc_target, 16'hFF86);
      check("neg_off_cnt", bus.taken_cnt, 4);
      tick(); tick();

      // Back-to-back with br_valid held: BGT taken (0x100+1+0x10), then BEQ not taken
      present(2'b10, 8'h10, 16'h0100, 16'h0009, 16'h0003, 1'b0, 2'b10);
      tick();
      bus.br_cond = 2'b00; bus.br_pc = 16'h0200; bus.op1_in = 16'h00AA; bus.r15_in = 16'h00BB;
      check("b2b_c1_op1", bus.cmp_op1, 16'h0009);
      check("b2b_c1_r15", bus.cmp_r15, 16'h0003);
      tick(); bus.cmp_branch = 2'b01;
      check("b2b_c2_pc_load", bus.pc_load, 1);
      check("b2b_c2_target", bus.pc_target, 16'h0111);
      tick();
      check("b2b_c3_ready", bus.br_ready, 0);
      check("b2b_c3_op1", bus.cmp_op1, 16'h0009);
      tick();
      check("b2b_c4_ready", bus.br_ready, 1);
      check("b2b_c4_r15", bus.cmp_r15, 16'h0003);
      tick(); bus.br_valid = 1'b0;
      check("b2b_c5_ready", bus.br_ready, 0);
      check("b2b_c5_op1", bus.cmp_op1, 16'h00AA);
      check("b2b_c5_r15", bus.cmp_r15, 16'h00BB);
      tick();
      check("b2b_c6_taken", bus.taken, 0);
      check("b2b_c6_ready", bus.br_ready, 1);
      check("b2b_c6_cnt", bus.taken_cnt, 5);

      // Asynchronous reset in the middle of a flush
      present(2'b11, 8'h03, 16'h0030, 16'h0000, 16'h0000, 1'b0, 2'b00);
      tick(); bus.br_valid = 1'b0;
      tick();
      check("midrst_pre_flush", bus.flush, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_flush", bus.flush, 0);
      check("midrst_pc_load", bus.pc_load, 0);
      check("midrst_ready", bus.br_ready, 1);
      check("midrst_cnt", bus.taken_cnt, 0);
      check("midrst_target", bus.pc_target, 0);
      #1 rst_n = 1'b1;
      tick();
      check("postrst_ready", bus.br_ready, 1);
      check("postrst_pc_load", bus.pc_load, 0);
      check("postrst_flush", bus.flush, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
